// File: rtl/core_result_aggregator_pkg.sv
// Shared types and default sizes for the core result aggregator.
package core_result_aggregator_pkg;

  localparam int unsigned CORES_MAX = 8;
  localparam int unsigned RESULT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    TMO
  } agg_state_t;

endpackage

// File: rtl/core_result_aggregator_if.sv
// Bus between the core array / run controller and the result aggregator.
interface core_result_aggregator_if
  import core_result_aggregator_pkg::*;
#(
  parameter int unsigned NUM_CORES = CORES_MAX,
  parameter int unsigned DATA_W    = RESULT_W,
  parameter int unsigned SUM_W     = 12,
  parameter int unsigned CYC_W     = 16
);

  logic                        start;
  logic [NUM_CORES-1:0]        core_en;
  logic [NUM_CORES-1:0]        strobe;
  logic [NUM_CORES*DATA_W-1:0] result;
  logic [NUM_CORES-1:0]        done_mask;
  logic [SUM_W-1:0]            total;
  logic [CYC_W-1:0]            cycles;
  logic                        busy;
  logic                        all_done;
  logic                        timeout;
  logic                        overflow;

  modport master (
    output start, core_en, strobe, result,
    input  done_mask, total, cycles, busy, all_done, timeout, overflow
  );

  modport slave (
    input  start, core_en, strobe, result,
    output done_mask, total, cycles, busy, all_done, timeout, overflow
  );

endinterface

// File: rtl/core_result_aggregator_done_tracker.sv
// Per-core tracker: strobe falling-edge detect, result capture, done and pending flags.
module core_result_aggregator_done_tracker
  import core_result_aggregator_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_cap_en,
  input  logic              i_strobe,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_drain,
  output logic              o_cap_c,
  output logic              o_done,
  output logic              o_pending,
  output logic [DATA_W-1:0] o_captured
);

  logic              r_strobe_q;
  logic              r_done;
  logic              r_pending;
  logic [DATA_W-1:0] r_captured;
  logic              w_fall;

  assign w_fall  = r_strobe_q & ~i_strobe;
  // Only the first enabled fall of a run is taken.
  assign o_cap_c = i_cap_en & w_fall & ~r_done;

  // Previous strobe level, tracked in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe_q <= 1'b0;
    end else begin
      r_strobe_q <= i_strobe;
    end
  end

  // Capture on first fall; a capture marks the core pending until the accumulator drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
      r_captured <= '0;
    end else if (i_clear) begin
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
      r_captured <= '0;
    end else if (o_cap_c) begin
      r_done     <= 1'b1;
      r_pending  <= 1'b1;
      r_captured <= i_result;
    end else if (i_drain) begin
      r_pending  <= 1'b0;
    end
  end

  assign o_done     = r_done;
  assign o_pending  = r_pending;
  assign o_captured = r_captured;

endmodule

// File: rtl/core_result_aggregator.sv
// Run monitor: collects one result per enabled core, sums them with saturation and times the run.
module core_result_aggregator
  import core_result_aggregator_pkg::*;
#(
  parameter int unsigned NUM_CORES      = CORES_MAX,
  parameter int unsigned DATA_W         = RESULT_W,
  parameter int unsigned SUM_W          = 12,
  parameter int unsigned CYC_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  core_result_aggregator_if.slave  bus
);

  agg_state_t           r_state;
  logic [NUM_CORES-1:0] r_en_q;
  logic [CYC_W-1:0]     r_cycles;
  logic [SUM_W-1:0]     r_total;
  logic                 r_overflow;
  logic                 r_busy;
  logic                 r_all_done;
  logic                 r_timeout;

  logic [NUM_CORES-1:0] w_cap;
  logic [NUM_CORES-1:0] w_done;
  logic [NUM_CORES-1:0] w_pend;
  logic [NUM_CORES-1:0] w_drain_oh;
  logic [NUM_CORES-1:0] w_drain;
  logic [DATA_W-1:0]    w_captured [NUM_CORES];
  logic [DATA_W-1:0]    w_drain_val;
  logic [SUM_W:0]       w_sum;
  logic [CYC_W-1:0]     w_cyc_nxt;
  logic                 w_drain_act;
  logic                 w_last;
  logic                 w_tmo_hit;

  // One tracker per core channel.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    core_result_aggregator_done_tracker #(
      .DATA_W (DATA_W)
    ) u_trk (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (bus.start),
      .i_cap_en   ((r_state == RUN) && r_en_q[gi]),
      .i_strobe   (bus.strobe[gi]),
      .i_result   (bus.result[gi*DATA_W +: DATA_W]),
      .i_drain    (w_drain[gi]),
      .o_cap_c    (w_cap[gi]),
      .o_done     (w_done[gi]),
      .o_pending  (w_pend[gi]),
      .o_captured (w_captured[gi])
    );
  end

  // Lowest-index pending core is drained first; start suppresses draining.
  assign w_drain_act = ((r_state == RUN) || (r_state == DRAIN) || (r_state == TMO)) && !bus.start;
  assign w_drain_oh  = w_pend & (~w_pend + NUM_CORES'(1));
  assign w_drain     = w_drain_act ? w_drain_oh : '0;

  // Result mux for the selected pending core.
  always_comb begin
    w_drain_val = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_drain_oh[i]) begin
        w_drain_val = w_drain_val | w_captured[i];
      end
    end
  end

  assign w_sum     = (SUM_W+1)'(r_total) + (SUM_W+1)'(w_drain_val);
  assign w_cyc_nxt = (r_cycles == '1) ? r_cycles : r_cycles + CYC_W'(1);
  assign w_last    = ((w_done | w_cap) == r_en_q);
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (32'(w_cyc_nxt) == TIMEOUT_CYCLES);

  // Run FSM with cycle counter; completion takes priority over timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en_q     <= '0;
      r_cycles   <= '0;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (bus.start) begin
      r_state    <= RUN;
      r_en_q     <= bus.core_en;
      r_cycles   <= '0;
      r_busy     <= 1'b1;
      r_all_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_cycles <= w_cyc_nxt;
          if (w_last) begin
            r_state <= DRAIN;
          end else if (w_tmo_hit) begin
            r_state   <= TMO;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_pend == '0) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_all_done <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Saturating accumulator with sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.start) begin
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else if (|w_drain) begin
      if (w_sum[SUM_W]) begin
        r_total    <= '1;
        r_overflow <= 1'b1;
      end else begin
        r_total    <= w_sum[SUM_W-1:0];
      end
    end
  end

  assign bus.done_mask = w_done;
  assign bus.total     = r_total;
  assign bus.cycles    = r_cycles;
  assign bus.busy      = r_busy;
  assign bus.all_done  = r_all_done;
  assign bus.timeout   = r_timeout;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_core_result_aggregator.sv
// Directed bench for core_result_aggregator with a run-level reference model.
module tb_core_result_aggregator;

  localparam int unsigned NC  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 50;
  localparam int SUM_MAX = 255;
  localparam int CYC_MAX = 65535;

  logic clk;
  logic reset;

  core_result_aggregator_if #(.NUM_CORES(NC), .DATA_W(DW), .SUM_W(SW), .CYC_W(CW)) bus ();

  core_result_aggregator #(
    .NUM_CORES      (NC),
    .DATA_W         (DW),
    .SUM_W          (SW),
    .CYC_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase, captured set, pending set and running sum.
  // phase: 0 idle, 1 running, 2 draining, 3 complete, 4 timed out
  int       m_phase;
  int       m_cycles;
  int       m_total;
  bit       m_ovf;
  bit [3:0] m_done, m_pend, m_enq, m_sq;
  int       m_cap [NC];
  bit [3:0] m_fall;
  bit       m_pend_was_empty;
  int       m_k;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0; m_cycles = 0; m_total = 0; m_ovf = 0;
        m_done = 0; m_pend = 0; m_enq = 0; m_sq = 0;
        for (int i = 0; i < NC; i++) m_cap[i] = 0;
      end else begin
        m_fall = m_sq & ~bus.strobe;
        if (bus.start) begin
          m_phase = 1; m_cycles = 0; m_total = 0; m_ovf = 0;
          m_done = 0; m_pend = 0; m_enq = bus.core_en;
          for (int i = 0; i < NC; i++) m_cap[i] = 0;
        end else begin
          m_pend_was_empty = (m_pend == 0);
          if ((m_phase == 1 || m_phase == 2 || m_phase == 4) && m_pend != 0) begin
            m_k = -1;
            for (int i = NC - 1; i >= 0; i--) if (m_pend[i]) m_k = i;
            m_total = m_total + m_cap[m_k];
            if (m_total > SUM_MAX) begin
              m_total = SUM_MAX;
              m_ovf = 1;
            end
            m_pend[m_k] = 0;
          end
          if (m_phase == 1) begin
            if (m_cycles < CYC_MAX) m_cycles++;
            for (int i = 0; i < NC; i++) begin
              if (m_fall[i] && m_enq[i] && !m_done[i]) begin
                m_cap[i]  = int'(bus.result[i*DW +: DW]);
                m_done[i] = 1;
                m_pend[i] = 1;
              end
            end
            if (m_done == m_enq) m_phase = 2;
            else if (m_cycles == TMO) m_phase = 4;
          end else if (m_phase == 2 && m_pend_was_empty) begin
            m_phase = 3;
          end
        end
        m_sq = bus.strobe;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("done_mask", 32'(bus.done_mask), 32'(m_done));
        check("total",     32'(bus.total),     32'(m_total));
        check("cycles",    32'(bus.cycles),    32'(m_cycles));
        check("busy",      32'(bus.busy),      32'(m_phase == 1 || m_phase == 2));
        check("all_done",  32'(bus.all_done),  32'(m_phase == 3));
        check("timeout",   32'(bus.timeout),   32'(m_phase == 4));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
      end
    end
  end

  // Advance n active edges, then settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [3:0] en);
    bus.start   = 1'b1;
    bus.core_en = en;
    tick(1);
    bus.start   = 1'b0;
  endtask

  // Drive strobes low where 'low' is set, high elsewhere, for one edge.
  task automatic step(input logic [3:0] low);
    bus.strobe = ~low;
    tick(1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.core_en = '0;
    bus.strobe  = 4'hF;
    bus.result  = '0;
    tick(2);
    reset  = 1'b0;
    chk_on = 1'b1;
    tick(1);
    check("rst_total", 32'(bus.total), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);

    // Test 1: staggered falls at run cycles 5, 9, 12, 20
    bus.result = {8'd14, 8'd12, 8'd15, 8'd13};
    do_start(4'hF);
    for (int j = 1; j <= 20; j++) step({j == 20, j == 12, j == 9, j == 5});
    check("t1_cycles_at_last", 32'(bus.cycles), 32'd20);
    check("t1_done_mask", 32'(bus.done_mask), 32'hF);
    step(4'h0);
    step(4'h0);
    check("t1_total", 32'(bus.total), 32'd54);
    check("t1_all_done", 32'(bus.all_done), 32'd1);
    check("t1_cycles", 32'(bus.cycles), 32'd20);

    // No cores enabled: completes two edges after start with cycles = 1
    do_start(4'h0);
    step(4'h0);
    check("z_busy", 32'(bus.busy), 32'd1);
    check("z_cycles", 32'(bus.cycles), 32'd1);
    step(4'h0);
    check("z_all_done", 32'(bus.all_done), 32'd1);
    check("z_total", 32'(bus.total), 32'd0);

    // Test 2: simultaneous falls drain one per cycle
    bus.result = {8'd4, 8'd3, 8'd2, 8'd1};
    do_start(4'hF);
    step(4'h0);
    step(4'h0);
    step(4'hF);
    check("t2_total0", 32'(bus.total), 32'd0);
    step(4'hF); check("t2_total1", 32'(bus.total), 32'd1);
    step(4'hF); check("t2_total3", 32'(bus.total), 32'd3);
    step(4'hF); check("t2_total6", 32'(bus.total), 32'd6);
    step(4'hF); check("t2_total10", 32'(bus.total), 32'd10);
    check("t2_not_done_yet", 32'(bus.all_done), 32'd0);
    step(4'hF); check("t2_all_done", 32'(bus.all_done), 32'd1);
    step(4'h0);

    // Test 3: saturation to 255 with sticky overflow, cleared by the next start
    bus.result = {8'd0, 8'd0, 8'd100, 8'd200};
    do_start(4'b0011);
    step(4'h0);
    step(4'b0011);
    step(4'h0);
    check("t3_partial", 32'(bus.total), 32'd200);
    step(4'h0);
    step(4'h0);
    check("t3_total", 32'(bus.total), 32'd255);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    check("t3_all_done", 32'(bus.all_done), 32'd1);
    do_start(4'b0011);
    check("t3_clr_total", 32'(bus.total), 32'd0);
    check("t3_clr_overflow", 32'(bus.overflow), 32'd0);

    // Test 4: core 2 silent, run aborts when cycles reaches 50 (restart while running)
    bus.result = {8'd7, 8'd99, 8'd6, 8'd5};
    do_start(4'hF);
    for (int j = 1; j <= 49; j++) step({j == 5, 1'b0, j == 4, j == 3});
    check("t4_pre_timeout", 32'(bus.timeout), 32'd0);
    step(4'h0);
    check("t4_timeout", 32'(bus.timeout), 32'd1);
    check("t4_cycles", 32'(bus.cycles), 32'd50);
    check("t4_all_done", 32'(bus.all_done), 32'd0);
    check("t4_core2", 32'(bus.done_mask[2]), 32'd0);
    check("t4_total", 32'(bus.total), 32'd18);
    step(4'h0);
    step(4'h0);
    check("t4_cycles_frozen", 32'(bus.cycles), 32'd50);

    // Test 5: masked core and repeated fall ignored
    bus.result = {8'd0, 8'd21, 8'd33, 8'd9};
    do_start(4'b0101);
    for (int j = 1; j <= 8; j++) begin
      step({1'b0, j == 8, j == 2, (j == 3 || j == 6)});
      if (j == 7) check("t5_mask_mid", 32'(bus.done_mask), 32'b0001);
    end
    check("t5_cycles", 32'(bus.cycles), 32'd8);
    step(4'h0);
    check("t5_not_done", 32'(bus.all_done), 32'd0);
    step(4'h0);
    check("t5_all_done", 32'(bus.all_done), 32'd1);
    check("t5_total", 32'(bus.total), 32'd30);
    check("t5_mask", 32'(bus.done_mask), 32'b0101);

    // Start coincident with a fall: that fall is not captured
    bus.result = {8'd0, 8'd0, 8'd0, 8'd42};
    bus.strobe = 4'b1110;
    do_start(4'b0001);
    step(4'b0001);
    step(4'b0001);
    check("sc_no_capture", 32'(bus.done_mask), 32'd0);
    step(4'h0);
    step(4'b0001);
    check("sc_capture_cycles", 32'(bus.cycles), 32'd4);
    step(4'h0);
    step(4'h0);
    check("sc_total", 32'(bus.total), 32'd42);
    check("sc_all_done", 32'(bus.all_done), 32'd1);

    // Test 6: reset mid-run, then a fresh run
    bus.result = {8'd4, 8'd3, 8'd2, 8'd1};
    do_start(4'hF);
    step(4'b0001);
    step(4'h0);
    step(4'h0);
    reset = 1'b1;
    #1;
    check("t6_rst_mask",    32'(bus.done_mask), 32'd0);
    check("t6_rst_total",   32'(bus.total),     32'd0);
    check("t6_rst_cycles",  32'(bus.cycles),    32'd0);
    check("t6_rst_busy",    32'(bus.busy),      32'd0);
    check("t6_rst_done",    32'(bus.all_done),  32'd0);
    check("t6_rst_timeout", 32'(bus.timeout),   32'd0);
    check("t6_rst_ovf",     32'(bus.overflow),  32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    do_start(4'hF);
    step(4'h0);
    check("t6_cycles1", 32'(bus.cycles), 32'd1);
    check("t6_busy", 32'(bus.busy), 32'd1);
    step(4'h0);
    check("t6_cycles2", 32'(bus.cycles), 32'd2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
